// File: rtl/ir_pkg.sv
// Shared types and constants for the IR key-event controller.
package ir_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned TYPE_W = 2;

    localparam logic [TYPE_W-1:0] EVT_PRESS   = 2'b01;
    localparam logic [TYPE_W-1:0] EVT_REPEAT  = 2'b10;
    localparam logic [TYPE_W-1:0] EVT_RELEASE = 2'b11;

    // Byte offsets inside a 32-bit decoded frame
    localparam int unsigned FRM_ADDR_LSB = 0;
    localparam int unsigned FRM_EXT_LSB  = 8;
    localparam int unsigned FRM_CMD_LSB  = 16;
    localparam int unsigned FRM_NCMD_LSB = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RPT    = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [BYTE_W-1:0] addr;
        logic [BYTE_W-1:0] cmd;
    } evt_t;

endpackage

// File: rtl/ir_evt_fifo.sv
// Small synchronous event FIFO; a write into an empty FIFO is visible the next cycle.
module ir_evt_fifo
    import ir_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  evt_t wdata_i,
    input  logic pop_i,
    output evt_t rdata_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    evt_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q;
    logic          do_push, do_pop;

    // A push into a full FIFO only lands when the head leaves in the same cycle
    assign do_pop  = pop_i & ~empty_q;
    assign do_push = push_i & (~full_q | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == CW'(0));
            full_q   <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/ir_key_ctrl.sv
// Converts decoded IR frame pulses into PRESS/REPEAT/RELEASE key events,
// buffered in a FIFO with a valid/ready interface and a sticky overflow flag.
module ir_key_ctrl
    import ir_pkg::*;
#(
    parameter int unsigned RELEASE_CYC    = 6000000,
    parameter int unsigned HOLD_CYC       = 25000000,
    parameter int unsigned RATE_CYC       = 5000000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter bit          ADDR_FILTER_EN = 1'b0,
    parameter logic [7:0]  ADDR           = 8'h00
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    input  logic        iEVT_READY,
    input  logic        iCLR_OVF,
    output logic        oEVT_VALID,
    output logic [1:0]  oEVT_TYPE,
    output logic [7:0]  oEVT_CMD,
    output logic [7:0]  oEVT_ADDR,
    output logic        oKEY_HELD,
    output logic        oOVERFLOW
);

    localparam int unsigned TMR_MAX_CYC = (HOLD_CYC > RATE_CYC) ? HOLD_CYC : RATE_CYC;
    localparam int unsigned RTW         = $clog2(RELEASE_CYC + 1);
    localparam int unsigned TW          = $clog2(TMR_MAX_CYC + 1);

    localparam logic [RTW-1:0] REL_LAST  = RTW'(RELEASE_CYC - 1);
    localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0]  RATE_LAST = TW'(RATE_CYC - 1);

    state_t            state_q, state_d;
    logic [RTW-1:0]    rel_tmr_q, rel_tmr_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [BYTE_W-1:0] cur_cmd_q, cur_cmd_d;
    logic [BYTE_W-1:0] cur_addr_q, cur_addr_d;
    logic [BYTE_W-1:0] pend_cmd_q, pend_cmd_d;
    logic [BYTE_W-1:0] pend_addr_q, pend_addr_d;
    logic              key_held_q;
    logic              ovf_q, ovf_d;

    logic [BYTE_W-1:0] f_addr, f_cmd;
    logic              frame_acc, same_key;
    logic [TW-1:0]     tick_last;
    logic              evt_push, fifo_pop, fifo_full, fifo_empty, drop;
    evt_t              evt_wdata, fifo_head;
    logic              unused_frame_bits;

    assign f_addr    = iDATA[FRM_ADDR_LSB +: BYTE_W];
    assign f_cmd     = iDATA[FRM_CMD_LSB +: BYTE_W];
    assign unused_frame_bits = ^{iDATA[FRM_EXT_LSB +: BYTE_W], iDATA[FRM_NCMD_LSB +: BYTE_W]};
    assign frame_acc = iDATA_READY & (!ADDR_FILTER_EN || (f_addr == ADDR));
    assign same_key  = (f_cmd == cur_cmd_q) && (f_addr == cur_addr_q);
    assign tick_last = (state_q == ST_HOLD) ? HOLD_LAST : RATE_LAST;

    // Key tracking FSM: a different key wins over everything, a matching frame
    // suppresses the release timeout, and a timeout suppresses the repeat tick.
    always_comb begin
        state_d     = state_q;
        rel_tmr_d   = (rel_tmr_q == '1) ? rel_tmr_q : rel_tmr_q + RTW'(1);
        tmr_d       = (tmr_q == '1) ? tmr_q : tmr_q + TW'(1);
        cur_cmd_d   = cur_cmd_q;
        cur_addr_d  = cur_addr_q;
        pend_cmd_d  = pend_cmd_q;
        pend_addr_d = pend_addr_q;
        evt_push    = 1'b0;
        evt_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                rel_tmr_d = '0;
                tmr_d     = '0;
                if (frame_acc) begin
                    evt_push   = 1'b1;
                    evt_wdata  = '{typ: EVT_PRESS, addr: f_addr, cmd: f_cmd};
                    cur_cmd_d  = f_cmd;
                    cur_addr_d = f_addr;
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD, ST_RPT: begin
                if (frame_acc && !same_key) begin
                    evt_push    = 1'b1;
                    evt_wdata   = '{typ: EVT_RELEASE, addr: cur_addr_q, cmd: cur_cmd_q};
                    pend_cmd_d  = f_cmd;
                    pend_addr_d = f_addr;
                    rel_tmr_d   = '0;
                    tmr_d       = '0;
                    state_d     = ST_SWITCH;
                end else if (!frame_acc && (rel_tmr_q == REL_LAST)) begin
                    evt_push  = 1'b1;
                    evt_wdata = '{typ: EVT_RELEASE, addr: cur_addr_q, cmd: cur_cmd_q};
                    rel_tmr_d = '0;
                    tmr_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    if (frame_acc) rel_tmr_d = '0;
                    if (tmr_q == tick_last) begin
                        evt_push  = 1'b1;
                        evt_wdata = '{typ: EVT_REPEAT, addr: cur_addr_q, cmd: cur_cmd_q};
                        tmr_d     = '0;
                        if (state_q == ST_HOLD) begin
                            rel_tmr_d = '0;
                            state_d   = ST_RPT;
                        end
                    end
                end
            end

            ST_SWITCH: begin
                evt_push   = 1'b1;
                evt_wdata  = '{typ: EVT_PRESS, addr: pend_addr_q, cmd: pend_cmd_q};
                cur_cmd_d  = pend_cmd_q;
                cur_addr_d = pend_addr_q;
                rel_tmr_d  = '0;
                tmr_d      = '0;
                state_d    = ST_HOLD;
            end

            default: begin
                rel_tmr_d = '0;
                tmr_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= ST_IDLE;
            rel_tmr_q   <= '0;
            tmr_q       <= '0;
            cur_cmd_q   <= '0;
            cur_addr_q  <= '0;
            pend_cmd_q  <= '0;
            pend_addr_q <= '0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rel_tmr_q   <= rel_tmr_d;
            tmr_q       <= tmr_d;
            cur_cmd_q   <= cur_cmd_d;
            cur_addr_q  <= cur_addr_d;
            pend_cmd_q  <= pend_cmd_d;
            pend_addr_q <= pend_addr_d;
            key_held_q  <= (state_d != ST_IDLE);
        end
    end

    assign fifo_pop = ~fifo_empty & iEVT_READY;
    assign drop     = evt_push & fifo_full & ~fifo_pop;

    // Sticky overflow: a new drop outranks a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (drop)          ovf_d = 1'b1;
        else if (iCLR_OVF) ovf_d = 1'b0;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    ir_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (iCLK),
        .rst_n   (iRST_n),
        .push_i  (evt_push),
        .wdata_i (evt_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign oEVT_VALID = ~fifo_empty;
    assign oEVT_TYPE  = fifo_head.typ;
    assign oEVT_CMD   = fifo_head.cmd;
    assign oEVT_ADDR  = fifo_head.addr;
    assign oKEY_HELD  = key_held_q;
    assign oOVERFLOW  = ovf_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Bench for ir_key_ctrl: table-driven key scenarios with an event scoreboard,
// plus hand-written overflow, address-filter and reset sequences.
module tb_ir_key_ctrl;
    import ir_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_ready, evt_ready, clr_ovf;
    logic [31:0] data;
    logic        evt_valid, key_held, ovf;
    logic [1:0]  evt_type;
    logic [7:0]  evt_cmd, evt_addr;

    logic        f_data_ready;
    logic [31:0] f_data;
    logic        f_valid, f_held, f_ovf;
    logic [1:0]  f_type;
    logic [7:0]  f_cmd, f_addr;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ir_key_ctrl #(
        .RELEASE_CYC(100), .HOLD_CYC(150), .RATE_CYC(40), .FIFO_DEPTH(4),
        .ADDR_FILTER_EN(1'b0), .ADDR(8'h00)
    ) u_dut (
        .iCLK(clk), .iRST_n(rst_n), .iDATA_READY(data_ready), .iDATA(data),
        .iEVT_READY(evt_ready), .iCLR_OVF(clr_ovf),
        .oEVT_VALID(evt_valid), .oEVT_TYPE(evt_type), .oEVT_CMD(evt_cmd),
        .oEVT_ADDR(evt_addr), .oKEY_HELD(key_held), .oOVERFLOW(ovf)
    );

    ir_key_ctrl #(
        .RELEASE_CYC(100), .HOLD_CYC(150), .RATE_CYC(40), .FIFO_DEPTH(4),
        .ADDR_FILTER_EN(1'b1), .ADDR(8'h10)
    ) u_flt (
        .iCLK(clk), .iRST_n(rst_n), .iDATA_READY(f_data_ready), .iDATA(f_data),
        .iEVT_READY(1'b1), .iCLR_OVF(1'b0),
        .oEVT_VALID(f_valid), .oEVT_TYPE(f_type), .oEVT_CMD(f_cmd),
        .oEVT_ADDR(f_addr), .oKEY_HELD(f_held), .oOVERFLOW(f_ovf)
    );

    typedef struct { int scen; int at; logic [7:0] cmd; logic [7:0] addr; } frm_t;
    typedef struct { int scen; int at; logic [1:0] typ; logic [7:0] cmd; logic [7:0] addr; } exp_t;

    frm_t frm_tab[$];
    exp_t exp_tab[$];
    exp_t exp_q[$];

    function automatic logic [31:0] mk_frame(input logic [7:0] cmd, input logic [7:0] addr);
        return {~cmd, cmd, ~addr, addr};
    endfunction

    function automatic void add_f(input int s, input int at, input logic [7:0] cmd, input logic [7:0] addr);
        frm_t f;
        f.scen = s; f.at = at; f.cmd = cmd; f.addr = addr;
        frm_tab.push_back(f);
    endfunction

    function automatic void add_e(input int s, input int at, input logic [1:0] typ,
                                  input logic [7:0] cmd, input logic [7:0] addr);
        exp_t e;
        e.scen = s; e.at = at; e.typ = typ; e.cmd = cmd; e.addr = addr;
        exp_tab.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every event the consumer accepts must be the next expected one
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_evt at cycle %0d: got type %0d cmd %0h, expected none",
                             cyc, evt_type, evt_cmd);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_type", 32'(evt_type), 32'(e.typ));
                    chk("evt_cmd", 32'(evt_cmd), 32'(e.cmd));
                    chk("evt_addr", 32'(evt_addr), 32'(e.addr));
                    if (e.at >= 0) chk("evt_cycle", cyc, e.at);
                end
            end
        end
    endtask

    task automatic run_scen(input int s);
        int   base;
        int   last;
        exp_t e;
        last = 0;
        foreach (exp_tab[i]) if (exp_tab[i].scen == s && exp_tab[i].at > last) last = exp_tab[i].at;
        tick();
        base = cyc;
        foreach (exp_tab[i]) begin
            if (exp_tab[i].scen == s) begin
                e = exp_tab[i];
                e.at = e.at + base;
                exp_q.push_back(e);
            end
        end
        for (int r = 0; r <= last + 5; r++) begin
            if (r > 0) tick();
            data_ready = 1'b0;
            foreach (frm_tab[i]) begin
                if (frm_tab[i].scen == s && frm_tab[i].at == r) begin
                    data_ready = 1'b1;
                    data = mk_frame(frm_tab[i].cmd, frm_tab[i].addr);
                end
            end
            if (r == 0 || r == last) chk($sformatf("held_lo_s%0d", s), 32'(key_held), 32'(0));
            if (r == 1 || r == last - 1) chk($sformatf("held_hi_s%0d", s), 32'(key_held), 32'(1));
        end
        data_ready = 1'b0;
        chk($sformatf("sb_drained_s%0d", s), exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int   base;
        exp_t e;

        // Scenario tables: frame stimulus and resulting events (cycle relative to scenario start)
        add_f(1, 0, 8'h45, 8'h00);
        add_e(1, 1, EVT_PRESS, 8'h45, 8'h00);   add_e(1, 101, EVT_RELEASE, 8'h45, 8'h00);

        for (int k = 0; k < 5; k++) add_f(2, k * 80, 8'h45, 8'h00);
        add_e(2, 1, EVT_PRESS, 8'h45, 8'h00);
        for (int k = 0; k < 7; k++) add_e(2, 151 + k * 40, EVT_REPEAT, 8'h45, 8'h00);
        add_e(2, 421, EVT_RELEASE, 8'h45, 8'h00);

        add_f(3, 0, 8'h45, 8'h00);              add_f(3, 50, 8'h46, 8'h00);
        add_e(3, 1, EVT_PRESS, 8'h45, 8'h00);   add_e(3, 51, EVT_RELEASE, 8'h45, 8'h00);
        add_e(3, 52, EVT_PRESS, 8'h46, 8'h00);  add_e(3, 152, EVT_RELEASE, 8'h46, 8'h00);

        add_f(4, 0, 8'h10, 8'h00);  add_f(4, 30, 8'h10, 8'h01);  add_f(4, 31, 8'h77, 8'h00);
        add_e(4, 1, EVT_PRESS, 8'h10, 8'h00);   add_e(4, 31, EVT_RELEASE, 8'h10, 8'h00);
        add_e(4, 32, EVT_PRESS, 8'h10, 8'h01);  add_e(4, 132, EVT_RELEASE, 8'h10, 8'h01);

        add_f(5, 0, 8'h20, 8'h00);              add_f(5, 100, 8'h20, 8'h00);
        add_e(5, 1, EVT_PRESS, 8'h20, 8'h00);
        for (int k = 0; k < 3; k++) add_e(5, 151 + k * 40, EVT_REPEAT, 8'h20, 8'h00);
        add_e(5, 251, EVT_RELEASE, 8'h20, 8'h00);

        add_f(6, 0, 8'h30, 8'h00);  add_f(6, 80, 8'h30, 8'h00);  add_f(6, 170, 8'h30, 8'h00);
        add_e(6, 1, EVT_PRESS, 8'h30, 8'h00);
        for (int k = 0; k < 3; k++) add_e(6, 151 + k * 40, EVT_REPEAT, 8'h30, 8'h00);
        add_e(6, 271, EVT_RELEASE, 8'h30, 8'h00);

        rst_n = 1'b0; data_ready = 1'b0; data = '0; evt_ready = 1'b1; clr_ovf = 1'b0;
        f_data_ready = 1'b0; f_data = '0;
        repeat (3) tick();
        chk("rst_valid", 32'(evt_valid), 32'(0));
        chk("rst_held", 32'(key_held), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        rst_n = 1'b1;
        fork monitor(); join_none

        for (int s = 1; s <= 6; s++) run_scen(s);

        // Overflow: consumer stalled while seven events are generated
        evt_ready = 1'b0;
        tick();
        base = cyc;
        for (int r = 0; r <= 115; r++) begin
            if (r > 0) tick();
            data_ready = 1'b0;
            clr_ovf = 1'b0;
            case (r)
                0: begin data_ready = 1'b1; data = mk_frame(8'h61, 8'h00); end
                2: begin data_ready = 1'b1; data = mk_frame(8'h62, 8'h00); end
                5: begin data_ready = 1'b1; data = mk_frame(8'h63, 8'h00); end
                8: begin data_ready = 1'b1; data = mk_frame(8'h64, 8'h00); clr_ovf = 1'b1; end
                default: ;
            endcase
            if (r == 4 || r == 9) begin
                chk("stall_valid", 32'(evt_valid), 32'(1));
                chk("stall_head_type", 32'(evt_type), 32'(EVT_PRESS));
                chk("stall_head_cmd", 32'(evt_cmd), 32'(8'h61));
            end
            if (r == 6) chk("ovf_before_drop", 32'(ovf), 32'(0));
            if (r == 7) chk("ovf_set", 32'(ovf), 32'(1));
            if (r == 9) chk("ovf_set_beats_clr", 32'(ovf), 32'(1));
            if (r == 12) begin
                add_e(0, -1, EVT_PRESS, 8'h61, 8'h00);  add_e(0, -1, EVT_RELEASE, 8'h61, 8'h00);
                add_e(0, -1, EVT_PRESS, 8'h62, 8'h00);  add_e(0, -1, EVT_RELEASE, 8'h62, 8'h00);
                add_e(0, base + 110, EVT_RELEASE, 8'h64, 8'h00);
                foreach (exp_tab[i]) if (exp_tab[i].scen == 0) begin e = exp_tab[i]; exp_q.push_back(e); end
                evt_ready = 1'b1;
            end
            if (r == 16) begin
                chk("drain_valid_lo", 32'(evt_valid), 32'(0));
                chk("drain_left", exp_q.size(), 1);
                chk("ovf_still_set", 32'(ovf), 32'(1));
                clr_ovf = 1'b1;
            end
            if (r == 17) chk("ovf_cleared", 32'(ovf), 32'(0));
        end
        clr_ovf = 1'b0;
        data_ready = 1'b0;
        chk("sb_drained_ovf", exp_q.size(), 0);
        exp_q.delete();

        // Address filter instance accepts only address 0x10
        tick();
        f_data_ready = 1'b1; f_data = mk_frame(8'h11, 8'h00);
        tick();
        f_data_ready = 1'b0;
        chk("flt_reject_valid", 32'(f_valid), 32'(0));
        chk("flt_reject_held", 32'(f_held), 32'(0));
        f_data_ready = 1'b1; f_data = mk_frame(8'h11, 8'h10);
        tick();
        f_data_ready = 1'b0;
        chk("flt_accept_valid", 32'(f_valid), 32'(1));
        chk("flt_accept_type", 32'(f_type), 32'(EVT_PRESS));
        chk("flt_accept_cmd", 32'(f_cmd), 32'(8'h11));
        chk("flt_accept_addr", 32'(f_addr), 32'(8'h10));
        chk("flt_accept_held", 32'(f_held), 32'(1));

        // Reset during a hold: outputs clear at once and the held key never releases
        tick();
        base = cyc;
        e.scen = 0; e.at = base + 1; e.typ = EVT_PRESS; e.cmd = 8'h50; e.addr = 8'h00;
        exp_q.push_back(e);
        data_ready = 1'b1; data = mk_frame(8'h50, 8'h00);
        tick();
        data_ready = 1'b0;
        repeat (59) tick();
        chk("pre_rst_held", 32'(key_held), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 32'(0));
        chk("mid_rst_type", 32'(evt_type), 32'(0));
        chk("mid_rst_cmd", 32'(evt_cmd), 32'(0));
        chk("mid_rst_addr", 32'(evt_addr), 32'(0));
        chk("mid_rst_held", 32'(key_held), 32'(0));
        chk("mid_rst_ovf", 32'(ovf), 32'(0));
        chk("mid_rst_flt_held", 32'(f_held), 32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (200) tick();
        chk("post_rst_held", 32'(key_held), 32'(0));
        chk("post_rst_no_evt", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
